// File: rtl/alu_pkg.sv
// alu_pkg: ALUctl opcode encodings and per-slice function selects shared by alu_32bit and alu_1bit_slice
package alu_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;
  localparam logic [2:0] SL_AND  = 3'd0;
  localparam logic [2:0] SL_OR   = 3'd1;
  localparam logic [2:0] SL_ADD  = 3'd2;
  localparam logic [2:0] SL_XOR  = 3'd3;
  localparam logic [2:0] SL_NOR  = 3'd4;
  localparam logic [2:0] SL_NAND = 3'd5;
  localparam logic [2:0] SL_ZERO = 3'd6;
endpackage

// File: rtl/alu_1bit_slice.sv
// alu_1bit_slice: one ALU bit; in a, b, cin, binv (invert b for subtract), op (slice function); out res, cout (zero unless adding)
module alu_1bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       binv,
  input  logic [2:0] op,
  output logic       res,
  output logic       cout
);
  logic bb;
  assign bb = b ^ binv;
  assign res = op == SL_AND  ? a & b :
               op == SL_OR   ? a | b :
               op == SL_ADD  ? a ^ bb ^ cin :
               op == SL_XOR  ? a ^ b :
               op == SL_NOR  ? ~(a | b) :
               op == SL_NAND ? ~(a & b) : 1'b0;
  assign cout = (op == SL_ADD) & ((a & bb) | (cin & (a ^ bb)));
endmodule

// File: rtl/alu_32bit.sv
// alu_32bit: registered 32-bit ripple ALU; in clk, reset, ALUctl, A, B; out result, carryOut, Zero, carryFlag, overflowFlag (1-cycle latency)
module alu_32bit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ALUctl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic [31:0] carryOut,
  output logic        Zero,
  output logic        carryFlag,
  output logic        overflowFlag
);
  logic [2:0]  sop;
  logic        binv, slt, arith, ovf;
  logic [31:0] s, co, ci, nres;
  always_comb begin
    sop = ALUctl == ALU_AND  ? SL_AND :
          ALUctl == ALU_OR   ? SL_OR :
          ALUctl == ALU_XOR  ? SL_XOR :
          ALUctl == ALU_NOR  ? SL_NOR :
          ALUctl == ALU_NAND ? SL_NAND :
          (ALUctl == ALU_ADD || ALUctl == ALU_SUB || ALUctl == ALU_SLT) ? SL_ADD : SL_ZERO;
    binv = ALUctl == ALU_SUB || ALUctl == ALU_SLT;
    slt = ALUctl == ALU_SLT;
    arith = ALUctl == ALU_ADD || ALUctl == ALU_SUB;
  end
  // slice 0 takes the subtract +1 as its carry-in; the rest ripple
  assign ci = {co[30:0], binv};
  for (genvar g = 0; g < 32; g++) begin : gen_slice
    alu_1bit_slice u_slice (
      .a(A[g]), .b(B[g]), .cin(ci[g]), .binv(binv), .op(sop),
      .res(s[g]), .cout(co[g])
    );
  end
  assign ovf = co[31] ^ co[30];
  assign nres = slt ? {31'b0, s[31] ^ ovf} : s;
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      carryOut <= '0;
      carryFlag <= 1'b0;
      overflowFlag <= 1'b0;
      Zero <= 1'b1;
    end else begin
      result <= nres;
      carryOut <= co;
      carryFlag <= co[31];
      overflowFlag <= arith & ovf;
      Zero <= nres == 32'h0;
    end
  end
endmodule

// File: tb/tb_alu_32bit.sv
// tb_alu_32bit: directed-vector scoreboard bench for alu_32bit
module tb_alu_32bit;
  import alu_pkg::*;
  logic        clk = 1'b0, reset = 1'b1;
  logic [3:0]  ALUctl = 4'b0;
  logic [31:0] A = '0, B = '0;
  logic [31:0] result, carryOut;
  logic        Zero, carryFlag, overflowFlag;
  typedef struct {
    string       name;
    logic [31:0] r, c;
    logic        cf, of, z;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  alu_32bit dut (
    .clk(clk), .reset(reset), .ALUctl(ALUctl), .A(A), .B(B),
    .result(result), .carryOut(carryOut), .Zero(Zero),
    .carryFlag(carryFlag), .overflowFlag(overflowFlag)
  );
  function automatic logic [31:0] carry_vec(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] bx, cin_bits;
    logic [32:0] sum;
    logic        c0;
    if (op == ALU_ADD) begin
      bx = b;
      c0 = 1'b0;
    end else if (op == ALU_SUB || op == ALU_SLT) begin
      bx = ~b;
      c0 = 1'b1;
    end else
      return 32'h0;
    sum = {1'b0, a} + {1'b0, bx} + {32'h0, c0};
    cin_bits = a ^ bx ^ sum[31:0];
    return {sum[32], cin_bits[31:1]};
  endfunction
  task automatic apply(string name, logic rst, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                       logic [31:0] r, logic cf, logic of, logic z);
    exp_t e;
    @(negedge clk);
    reset = rst;
    ALUctl = op;
    A = a;
    B = b;
    e.name = name;
    e.r = r;
    e.c = rst ? 32'h0 : carry_vec(op, a, b);
    e.cf = cf;
    e.of = of;
    e.z = z;
    q.push_back(e);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (result !== e.r || carryOut !== e.c || carryFlag !== e.cf || overflowFlag !== e.of || Zero !== e.z) begin
        miscompares++;
        $display("FAIL %s: got r=%h c=%h cf=%b of=%b z=%b, need r=%h c=%h cf=%b of=%b z=%b",
                 e.name, result, carryOut, carryFlag, overflowFlag, Zero, e.r, e.c, e.cf, e.of, e.z);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    apply("reset",      1, ALU_ADD,  32'h1234_5678, 32'h1111_1111, 32'h0, 0, 0, 1);
    apply("and",        0, ALU_AND,  32'h1010_F00C, 32'h040F_0E0C, 32'h0000_000C, 0, 0, 0);
    apply("or",         0, ALU_OR,   32'h1010_F00C, 32'h040F_0E0C, 32'h141F_FE0C, 0, 0, 0);
    apply("nor",        0, ALU_NOR,  32'h1010_F00C, 32'h040F_0E0C, 32'hEBE0_01F3, 0, 0, 0);
    apply("nand",       0, ALU_NAND, 32'h1010_F00C, 32'h040F_0E0C, 32'hFFFF_FFF3, 0, 0, 0);
    apply("add_carry",  0, ALU_ADD,  32'hFFFF_FFFE, 32'h1000_0001, 32'h0FFF_FFFF, 1, 0, 0);
    apply("sub",        0, ALU_SUB,  32'h0FFF_FFFF, 32'h0000_0004, 32'h0FFF_FFFB, 1, 0, 0);
    apply("xor",        0, ALU_XOR,  32'h0FFF_FFFF, 32'h0000_0004, 32'h0FFF_FFFB, 0, 0, 0);
    apply("sub_borrow", 0, ALU_SUB,  32'h0FFF_FFFB, 32'hFFFF_FFFE, 32'h0FFF_FFFD, 0, 0, 0);
    apply("add_ovf",    0, ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0);
    apply("slt_true",   0, ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 0, 0);
    apply("slt_false",  0, ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 1);
    apply("slt_ovf",    0, ALU_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1, 0, 0);
    apply("sub_ovf",    0, ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 1, 0);
    apply("sub_zero",   0, ALU_SUB,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1, 0, 1);
    apply("op_1111",    0, 4'b1111,  32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 0, 0, 1);
    apply("op_0100",    0, 4'b0100,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 1);
    apply("add_wrap",   0, ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1);
    apply("add_pre",    0, ALU_ADD,  32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 0, 0, 0);
    apply("mid_reset",  1, ALU_ADD,  32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 0, 0, 1);
    apply("post_reset", 0, ALU_ADD,  32'h0000_0005, 32'h0000_0006, 32'h0000_000B, 0, 0, 0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses left, need 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_32bit.md
ALU_32BIT -- requirements
Module: alu_32bit

Interface
REQ-001 Ports SHALL be (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ALUctl  input  4  operation select.
- A  input  32  operand A.
- B  input  32  operand B.
- result  output  32  registered operation result.
- carryOut  output  32  registered per-bit carry-out vector of the bit slices.
- Zero  output  1  registered; 1 when result is zero.
- carryFlag  output  1  registered carry out of bit 31.
- overflowFlag  output  1  registered signed-overflow flag.
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 The block SHALL have no parameters; the width is fixed at 32.

Function
REQ-004 ALUctl encodings SHALL be:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 XOR
- 0110 SUB (A + ~B + 1)
- 0111 SLT (signed)
- 1100 NOR
- 1101 NAND
REQ-005 All outputs SHALL be registered, with latency exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-006 ADD/SUB SHALL use a 32-slice ripple carry chain; carryOut[i] SHALL be the carry out of slice i, and carry-in to slice 0 SHALL be 0 for ADD and 1 for SUB/SLT.
REQ-007 carryFlag SHALL equal carryOut[31] for ADD/SUB/SLT; for SUB, 1 means no borrow.
REQ-008 overflowFlag SHALL equal carryOut[31] XOR carryOut[30] for ADD/SUB, and 0 for all other operations.
REQ-009 SLT SHALL perform the subtraction A-B; result SHALL be 32'd1 when (sum[31] XOR overflow) is 1, else 0; carryOut and carryFlag SHALL follow the subtraction, and overflowFlag SHALL be 0.
REQ-010 For logic ops (AND/OR/XOR/NOR/NAND), carryOut, carryFlag and overflowFlag SHALL be 0.
REQ-011 Zero SHALL be 1 exactly when the registered result equals 32'h0, including for undefined opcodes.
REQ-012 Undefined ALUctl codes SHALL produce result = 0, carryOut = 0, carryFlag = 0, overflowFlag = 0 and Zero = 1.
REQ-013 Arithmetic SHALL wrap modulo 2^32; there SHALL be no saturation.
REQ-014 Inputs SHALL be treated as combinational within the cycle; there SHALL be no handshake, and each cycle computes a new operation.

Reset
REQ-015 While reset is high at a rising edge, the outputs SHALL be: result = 0, carryOut = 0, carryFlag = 0, overflowFlag = 0, Zero = 1.
REQ-016 Reset SHALL take priority over inputs; an operation presented in a cycle where reset is asserted SHALL be discarded, and the first valid output SHALL appear one cycle after reset deasserts.

Structure
REQ-017 The ALUctl opcode constants SHALL reside in a shared package, alu_pkg.
REQ-018 One sub-module, alu_1bit_slice, SHALL implement a 1-bit slice:
- inputs: a, b, cin, invert-b, op.
- outputs: result bit, cout.
- the top SHALL instantiate it 32 times in a generate loop, followed by the output register stage.

Verification
REQ-019 A=0x1010F00C, B=0x040F0E0C:
- AND -> result 0x0000000C, Zero 0.
- OR -> 0x141FFE0C.
- NOR -> 0xEBE001F3.
- NAND -> 0xFFFFFFF3.
- In all four cases, carryOut=0 and both flags=0.
REQ-020 ADD A=0xFFFFFFFE, B=0x10000001 -> result 0x0FFFFFFF, carryOut 0xF0000000, carryFlag 1, overflowFlag 0.
REQ-021 A=0x0FFFFFFF, B=0x00000004:
- SUB -> result 0x0FFFFFFB, carryFlag 1, overflowFlag 0.
- XOR -> result 0x0FFFFFFB, flags 0.
REQ-022 SUB A=0x0FFFFFFB, B=0xFFFFFFFE -> result 0x0FFFFFFD, carryFlag 0, overflowFlag 0; ADD A=0x7FFFFFFF, B=1 -> result 0x80000000, overflowFlag 1, carryFlag 0.
REQ-023 Further directed cases:
- SLT A=0xFFFFFFFF, B=1 -> result 1.
- SUB A=B=0x12345678 -> result 0, Zero 1, carryFlag 1.
- Opcode 1111 -> result 0, Zero 1.
REQ-024 Assert reset mid-stream with ADD applied -> the next edge shows all outputs 0 and Zero 1; deassert -> the correct result appears after exactly one edge.
